// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the PISO serializer.
// Imported by the interface, the shift cell and the top.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Handshake and data bundle between a word source and the serializer.
// master drives load/D/stall; slave returns the serial stream.
interface piso_serializer_if
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int CW = cnt_w(WIDTH);

  logic             load;
  logic [WIDTH-1:0] D;
  logic             stall;
  logic             ready;
  logic             serial_out;
  logic             valid;
  logic             done;
  logic [CW-1:0]    count;

  modport master (
    output load,
    output D,
    output stall,
    input  ready,
    input  serial_out,
    input  valid,
    input  done,
    input  count
  );

  modport slave (
    input  load,
    input  D,
    input  stall,
    output ready,
    output serial_out,
    output valid,
    output done,
    output count
  );
endinterface

// File: rtl/piso_serializer_shift_stage.sv
// One bit of the shift register: parallel load or neighbour shift,
// with a hold enable and asynchronous active-low clear.
module piso_serializer_shift_stage (
  input  logic clock,
  input  logic nReset,
  input  logic en,
  input  logic sel_load,
  input  logic pbit,
  input  logic nbit,
  output logic q
);
  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = sel_load ? pbit : nbit;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: FSM, bit counter and
// a generated chain of shift cells.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clock,
  input  logic                 nReset,
  piso_serializer_if.slave     bus
);
  localparam int CW = cnt_w(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] nbr;
  logic             accept;
  logic             adv;
  logic             last;

  assign accept = (state_q == IDLE) && bus.load;
  assign adv    = (state_q == SHIFT) && !bus.stall;
  assign last   = (cnt_q == CW'(1));

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.load) state_d = SHIFT;
      SHIFT: if (adv && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = CW'(WIDTH);
    end else if (adv) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Vacated end of the chain is fed with zero.
  always_comb begin
    nbr = '0;
    if (LSB_FIRST) begin
      nbr[WIDTH-2:0] = shreg[WIDTH-1:1];
    end else begin
      nbr[WIDTH-1:1] = shreg[WIDTH-2:0];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    piso_serializer_shift_stage u_cell (
      .clock    (clock),
      .nReset   (nReset),
      .en       (accept | adv),
      .sel_load (accept),
      .pbit     (bus.D[i]),
      .nbit     (nbr[i]),
      .q        (shreg[i])
    );
  end

  always_comb begin
    bus.ready      = 1'b1;
    bus.valid      = 1'b0;
    bus.done       = 1'b0;
    bus.serial_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
      end
      SHIFT: begin
        bus.ready      = 1'b0;
        bus.valid      = !bus.stall;
        bus.done       = last && !bus.stall;
        bus.serial_out = LSB_FIRST ? shreg[0]
                                   : shreg[WIDTH-1];
      end
      default: begin
        bus.ready = 1'b1;
      end
    endcase
  end

  assign bus.count = cnt_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed plus random bench for piso_serializer, checking an
// LSB-first and an MSB-first instance against an index-based model.
module tb_piso_serializer;
  localparam int W = 8;

  logic clock = 1'b0;
  logic nReset = 1'b1;

  piso_serializer_if #(.WIDTH(W)) if0 ();
  piso_serializer_if #(.WIDTH(W)) if1 ();

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clock  (clock),
    .nReset (nReset),
    .bus    (if0.slave)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clock  (clock),
    .nReset (nReset),
    .bus    (if1.slave)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;

  // Model: word in flight and how many of its bits were emitted.
  bit         m_busy = 1'b0;
  logic [7:0] m_word = '0;
  int         m_idx  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic l, input logic [7:0] d,
                       input logic s);
    if0.load = l; if0.D = d; if0.stall = s;
    if1.load = l; if1.D = d; if1.stall = s;
  endtask

  task automatic check_all(input logic s);
    logic       e_bl;
    logic       e_bm;
    logic       e_dn;
    logic [3:0] e_cnt;
    e_bl  = m_busy ? m_word[m_idx] : 1'b0;
    e_bm  = m_busy ? m_word[W-1-m_idx] : 1'b0;
    e_dn  = m_busy && (m_idx == W - 1) && !s;
    e_cnt = m_busy ? 4'(W - m_idx) : 4'd0;
    chk("lsb_ready", 32'(if0.ready), 32'(!m_busy));
    chk("lsb_valid", 32'(if0.valid), 32'(m_busy && !s));
    chk("lsb_done",  32'(if0.done),  32'(e_dn));
    chk("lsb_bit",   32'(if0.serial_out), 32'(e_bl));
    chk("lsb_count", 32'(if0.count), 32'(e_cnt));
    chk("msb_ready", 32'(if1.ready), 32'(!m_busy));
    chk("msb_valid", 32'(if1.valid), 32'(m_busy && !s));
    chk("msb_done",  32'(if1.done),  32'(e_dn));
    chk("msb_bit",   32'(if1.serial_out), 32'(e_bm));
    chk("msb_count", 32'(if1.count), 32'(e_cnt));
    if (if0.done === 1'b1) done_seen++;
  endtask

  task automatic model_step(input logic l, input logic [7:0] d,
                            input logic s);
    if (!nReset) begin
      m_busy = 1'b0; m_idx = 0;
    end else if (!m_busy) begin
      if (l) begin
        m_busy = 1'b1; m_word = d; m_idx = 0;
      end
    end else if (!s) begin
      m_idx++;
      if (m_idx == W) begin
        m_busy = 1'b0; m_idx = 0;
      end
    end
  endtask

  task automatic cyc(input logic l, input logic [7:0] d,
                     input logic s);
    @(negedge clock);
    drive(l, d, s);
    #1;
    check_all(s);
    @(posedge clock);
    model_step(l, d, s);
  endtask

  // Drop reset mid-cycle and check outputs before any clock edge.
  task automatic mid_reset();
    @(negedge clock);
    #2 nReset = 1'b0;
    #1;
    m_busy = 1'b0; m_idx = 0;
    check_all(if0.stall);
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    @(negedge clock);
    nReset = 1'b1;
  endtask

  task automatic word(input logic [7:0] d);
    cyc(1'b1, d, 1'b0);
    for (int i = 0; i < W + 1; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    mid_reset();
    cyc(1'b0, 8'h00, 1'b0);

    word(8'hA5);
    word(8'hC3);

    done_seen = 0;
    cyc(1'b1, 8'h0F, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("stall_done_once", 32'(done_seen), 32'd1);

    cyc(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 2 * W + 1; i++) cyc(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 8'h00, 1'b0);

    cyc(1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0);
    mid_reset();
    word(8'h81);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) == 0, 8'($urandom),
          ($urandom % 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out stage that consumes a WIDTH-bit word held by the flip-flop register stage and shifts it out one bit per clock.
- Uses a load/ready handshake, a per-bit valid flag, a stall input and an end-of-word done pulse.
- Sits directly downstream of the word register; feeds serial links and bit-serial datapaths in the sequential-circuits set.

Parameters:
WIDTH, 8, number of bits per word (legal range 2..32)
LSB_FIRST, 1, 1 = bit 0 shifted out first; 0 = bit WIDTH-1 first

Ports:
clock  input  1  system clock; all state updates on rising edge
nReset  input  1  asynchronous, active-low reset
load  input  1  request to capture D; honoured only when ready=1
D  input  WIDTH  parallel word to serialize
stall  input  1  freezes shifting while high
ready  output  1  high when idle and able to accept load
serial_out  output  1  current serial bit
valid  output  1  serial_out carries a live data bit this cycle
done  output  1  one-cycle pulse marking the last bit of a word
count  output  $clog2(WIDTH+1)  bits remaining, including the current one

Behaviour:
- Reset: one clock, asynchronous and active-low (nReset). While nReset=0, immediately:
  - state=IDLE, shift register=0, bit counter=0
  - ready=1, serial_out=0, valid=0, done=0, count=0
- Deassertion of nReset takes effect on the next rising clock edge.
- FSM states: IDLE, SHIFT.
- IDLE: ready=1, valid=0, done=0, serial_out=0.
  - load=1 at a rising edge: capture D into the shift register, counter=WIDTH, go to SHIFT.
  - load=0: stay in IDLE.
- SHIFT: ready=0, valid=~stall.
  - serial_out = shreg[0] if LSB_FIRST, else shreg[WIDTH-1]; it is valid in the same cycle.
- SHIFT, stall=0 at a rising edge:
  - shift register moves one position toward the output end; the vacated end is filled with 0.
  - counter decrements by 1.
- SHIFT, stall=1 at a rising edge: shift register and counter hold.
  - serial_out keeps its value, valid=0, done=0.
- Last bit: done = (state==SHIFT) & (counter==1) & ~stall.
  - At that rising edge the counter goes to 0 and the state returns to IDLE.
- Latency:
  - First bit is on serial_out in the cycle after load is accepted.
  - The word occupies exactly WIDTH unstalled SHIFT cycles.
  - ready returns in the cycle after done.
- load while ready=0 (including the done cycle): ignored, no effect on the word in flight. There is no back-to-back overlap.
- D is sampled only on the accepted load edge; later changes to D are ignored.
- count output is the counter: WIDTH after accept, down to 1 on the last bit, 0 in IDLE.
- ready, valid, done and serial_out are decoded only from registered state; there is no combinational path from load or D to any output.
- Reset mid-word: the word is abandoned and all outputs immediately take their reset values. There is no partial done.

Decomposition:
- Shared package: state enum (IDLE, SHIFT) and a function returning the counter width $clog2(WIDTH+1).
- Natural sub-module: shift_stage.
  - One-bit cell: rising-edge register with async active-low clear and a 2:1 mux selecting parallel-load bit vs. neighbour bit, plus a hold enable.
  - Instantiated WIDTH times via a generate loop.
- FSM and counter stay in the top module.

Test Plan:
- Reset check: nReset=0 mid-cycle → all outputs (ready=1, valid=0, done=0, serial_out=0, count=0) go to reset values immediately, without waiting for a clock edge.
- Basic word: WIDTH=8, LSB_FIRST=1, load with D=8'hA5 → serial_out=1,0,1,0,0,1,0,1 on cycles 1..8 with valid=1.
  - done=1 only on cycle 8; ready=1 on cycle 9.
- MSB first: LSB_FIRST=0, D=8'hC3 → serial_out=1,1,0,0,0,0,1,1.
  - count goes 8,7,…,1,0.
- Stall: D=8'h0F, stall=1 for 3 cycles after the 2nd bit → serial_out holds 1 with valid=0 for 3 cycles.
  - Total SHIFT duration is 11 cycles; done appears once.
- Ignored load: load=1 and D=8'hFF held on every cycle of an 8'h00 word → all 8 bits are 0.
  - The new word is accepted only on the cycle ready=1; serial_out=1 for 8 cycles after that.
- Reset mid-word: nReset=0 after the 4th bit of 8'h5A → outputs immediately take reset values.
  - After release, load 8'h81 → clean 1,0,0,0,0,0,0,1 sequence.
